// File: rtl/axil_dmem_rd_slave_pkg.sv
// Shared definitions for the AXI4-Lite data-memory read slave: response codes and FSM states.

package axil_dmem_rd_slave_pkg;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  function automatic logic [1:0] resp_for(input logic in_range);
    return in_range ? RespOkay : RespSlverr;
  endfunction

endpackage

// File: rtl/axil_dmem_rd_slave_dmem_array.sv
// Word-organised RAM with a synchronous byte-strobed write port and a combinational read port.

module axil_dmem_rd_slave_dmem_array #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                clk_i,
  input  logic                wr_en_i,
  input  logic [IDX_W-1:0]    wr_idx_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic [DATA_W/8-1:0] wr_strb_i,
  input  logic [IDX_W-1:0]    rd_idx_i,
  output logic [DATA_W-1:0]   rd_data_o
);

  localparam int unsigned Lanes = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < Lanes; i++) begin
      if (wr_en_i && wr_strb_i[i]) begin
        mem_q[wr_idx_i][i*8 +: 8] <= wr_data_i[i*8 +: 8];
      end
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/axil_dmem_rd_slave.sv
// AXI4-Lite read responder for the data memory: fixed-latency single-outstanding reads,
// out-of-range addresses answered with SLVERR, plus an independent byte-strobed store port.

module axil_dmem_rd_slave
  import axil_dmem_rd_slave_pkg::*;
#(
  parameter int unsigned        ADDR_W      = 32,
  parameter int unsigned        DATA_W      = 32,
  parameter int unsigned        DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0]  BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned        LATENCY     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW = 4;

  // Range limits carry one extra bit so a window ending at 2^ADDR_W does not wrap to zero.
  localparam logic [ADDR_W:0]   BaseExt = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0]   SpanExt = (ADDR_W+1)'(4 * DEPTH_WORDS);
  localparam logic [ADDR_W:0]   EndExt  = BaseExt + SpanExt;
  localparam logic [CntW-1:0]   CntInit = CntW'((LATENCY > 1) ? (LATENCY - 2) : 0);

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W:0] addr_ext;
    addr_ext = {1'b0, addr};
    return (addr_ext >= BaseExt) && (addr_ext < EndExt);
  endfunction

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              inr_q, inr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic [ADDR_W-1:0] rd_off, wr_off;
  logic [IdxW-1:0]   rd_idx, wr_idx, mem_rd_idx;
  logic              rd_inr, wr_inr, cap_inr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              unused_addr_bits;

  // Byte offset within the window; bits [1:0] and anything above the index are don't-care.
  assign rd_off           = araddr - BASE_ADDR;
  assign wr_off           = wr_addr - BASE_ADDR;
  assign rd_idx           = rd_off[IdxW+1:2];
  assign wr_idx           = wr_off[IdxW+1:2];
  assign rd_inr           = addr_in_range(araddr);
  assign wr_inr           = addr_in_range(wr_addr);
  assign unused_addr_bits = ^{rd_off, wr_off};

  // With LATENCY==1 the capture happens on the AR handshake edge, so read the live address.
  assign mem_rd_idx = (state_q == StIdle) ? rd_idx : idx_q;
  assign cap_inr    = (state_q == StIdle) ? rd_inr : inr_q;

  axil_dmem_rd_slave_dmem_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IdxW)
  ) u_dmem_array (
    .clk_i     (clk),
    .wr_en_i   (wr_en & wr_inr),
    .wr_idx_i  (wr_idx),
    .wr_data_i (wr_data),
    .wr_strb_i (wr_strb),
    .rd_idx_i  (mem_rd_idx),
    .rd_data_o (mem_rd_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    inr_d   = inr_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;

    unique case (state_q)
      StIdle: begin
        if (arvalid) begin
          idx_d = rd_idx;
          inr_d = rd_inr;
          if (LATENCY == 1) begin
            state_d = StResp;
            rdata_d = cap_inr ? mem_rd_data : '0;
            rresp_d = resp_for(cap_inr);
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
          rdata_d = cap_inr ? mem_rd_data : '0;
          rresp_d = resp_for(cap_inr);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (rready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      inr_q   <= 1'b0;
      rdata_q <= '0;
      rresp_q <= RespOkay;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      inr_q   <= inr_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

  assign arready = (state_q == StIdle) & ~rst;
  assign rvalid  = (state_q == StResp);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule

// File: tb/tb_axil_dmem_rd_slave.sv
// Scoreboard bench: one LATENCY=1 slave at 0x8000_0000 and one LATENCY=4 slave at 0xFFFF_F000
// share a stimulus bus; sel picks which one sees AR/R traffic.

module tb_axil_dmem_rd_slave;

  localparam logic [31:0] Base0 = 32'h8000_0000;
  localparam logic [31:0] Base1 = 32'hFFFF_F000;
  localparam int          Lat0  = 1;
  localparam int          Lat1  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [31:0] araddr;
  logic        arvalid, rready;
  logic        wr_en;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;

  logic        arvalid0, arvalid1, rready0, rready1;
  logic        arready0, arready1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [1:0]  rresp0, rresp1;
  logic        arready_m, rvalid_m;
  logic [31:0] rdata_m;
  logic [1:0]  rresp_m;

  assign arvalid0  = arvalid & ~sel;
  assign arvalid1  = arvalid & sel;
  assign rready0   = rready & ~sel;
  assign rready1   = rready & sel;
  assign arready_m = sel ? arready1 : arready0;
  assign rvalid_m  = sel ? rvalid1 : rvalid0;
  assign rdata_m   = sel ? rdata1 : rdata0;
  assign rresp_m   = sel ? rresp1 : rresp0;

  axil_dmem_rd_slave #(.BASE_ADDR(Base0), .LATENCY(Lat0)) u_dut0 (
    .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid0), .arready(arready0),
    .rdata(rdata0), .rresp(rresp0), .rvalid(rvalid0), .rready(rready0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb)
  );

  axil_dmem_rd_slave #(.BASE_ADDR(Base1), .LATENCY(Lat1)) u_dut1 (
    .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid1), .arready(arready1),
    .rdata(rdata1), .rresp(rresp1), .rvalid(rvalid1), .rready(rready1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb)
  );

  always #5 clk = ~clk;

  bit   [31:0] model0 [1024];
  bit   [31:0] model1 [1024];
  logic [33:0] sb [$];
  int          total = 0;
  int          bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic model_hit(input logic s, input logic [31:0] a, output int idx);
    logic [32:0] base, ax;
    base = s ? {1'b0, Base1} : {1'b0, Base0};
    ax   = {1'b0, a};
    idx  = int'((a - base[31:0]) >> 2) & 1023;
    return (ax >= base) && (ax < base + 33'h1000);
  endfunction

  function automatic logic [33:0] model_read(input logic s, input logic [31:0] a);
    int idx;
    if (!model_hit(s, a, idx)) return {2'b10, 32'h0};
    return {2'b00, s ? model1[idx] : model0[idx]};
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb);
    int idx;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        if (model_hit(1'b0, a, idx)) model0[idx][b*8 +: 8] = d[b*8 +: 8];
        if (model_hit(1'b1, a, idx)) model1[idx][b*8 +: 8] = d[b*8 +: 8];
      end
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = strb;
    @(posedge clk); #1;
    wr_en = 1'b0;
    model_write(a, d, strb);
  endtask

  // hz: drive a full-word write to the same address on the AR handshake edge.
  task automatic do_read(input logic s, input logic [31:0] a, input int hold,
                         input logic hz, input logic [31:0] hz_d);
    int          n;
    logic [31:0] d0;
    logic [33:0] e;
    sel = s; araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready_m && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) check_val("ar_timeout", 1, 0);
    sb.push_back(model_read(s, a));
    if (hz) begin wr_en = 1'b1; wr_addr = a; wr_data = hz_d; wr_strb = 4'hF; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    if (hz) begin wr_en = 1'b0; model_write(a, hz_d, 4'hF); end
    n = 1;
    while (!rvalid_m && n < 50) begin @(posedge clk); #1; n++; end
    check_val($sformatf("latency@%h", a), n, s ? Lat1 : Lat0);
    d0 = rdata_m;
    for (int i = 0; i < hold; i++) begin
      check_val("hold_arready", arready_m, 0);
      @(posedge clk); #1;
      check_val("hold_rvalid", rvalid_m, 1);
      check_val("hold_rdata", rdata_m, d0);
    end
    rready = 1'b1;
    e = sb.pop_front();
    check_val($sformatf("rdata@%h", a), rdata_m, e[31:0]);
    check_val($sformatf("rresp@%h", a), rresp_m, e[33:32]);
    check_val("arready_in_rhs", arready_m, 0);
    @(posedge clk); #1;
    rready = 1'b0;
    check_val("arready_after", arready_m, 1);
    check_val("rvalid_after", rvalid_m, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sel = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_arready0", arready0, 0);
    check_val("rst_arready1", arready1, 0);
    check_val("rst_rvalid", {rvalid0, rvalid1}, 0);
    check_val("rst_rdata", {rdata0, rdata1}, 0);
    check_val("rst_rresp", {rresp0, rresp1}, 0);
    rst = 1'b0;
    #1;
    check_val("post_rst_arready", {arready0, arready1}, 2'b11);

    do_write(Base0, 32'hDEADBEEF, 4'hF);
    do_read(1'b0, Base0, 0, 1'b0, 0);

    do_write(32'hFFFF_F010, 32'h0BADF00D, 4'hF);
    do_read(1'b1, 32'hFFFF_F010, 3, 1'b0, 0);

    do_read(1'b0, 32'h8000_1000, 0, 1'b0, 0);
    do_read(1'b0, 32'h7FFF_FFFC, 0, 1'b0, 0);
    do_write(32'hFFFF_FFFC, 32'hCAFEF00D, 4'hF);
    do_read(1'b1, 32'hFFFF_FFFC, 0, 1'b0, 0);
    do_read(1'b1, 32'h0000_0000, 0, 1'b0, 0);
    do_read(1'b1, 32'hFFFF_EFFC, 1, 1'b0, 0);

    do_write(32'h8000_000C, 32'h11223344, 4'hF);
    do_write(32'h8000_000C, 32'hAABBCCDD, 4'b0101);
    do_read(1'b0, 32'h8000_000F, 0, 1'b0, 0);
    check_val("strb_model", model0[3], 32'h11BB33DD);

    do_write(32'h8000_0014, 32'h0, 4'hF);
    do_read(1'b0, 32'h8000_0014, 0, 1'b1, 32'h55);
    do_read(1'b0, 32'h8000_0014, 0, 1'b0, 0);

    // Reset during WAIT drops the pending read.
    sel = 1'b1; araddr = 32'hFFFF_F010; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_val("midrst_rvalid", rvalid1, 0);
    check_val("midrst_arready", {arready0, arready1}, 0);
    #3;
    rst = 1'b0;
    #1;
    check_val("postrst_arready", arready1, 1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check_val("no_stale_rvalid", rvalid1, 0);
    end
    do_read(1'b1, 32'hFFFF_F010, 0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
